ocs_tx_slot_sched: RTL

- Per-slot transmit scheduler for the OCS uplink.
- Consumes slot_start/slot_id from the OCS slot controller and shares the single optical TX datapath among P_NUM_REQ packet queues with round-robin arbitration.
- Each queue is tagged with the slot (circuit) it must use. A grant is issued only if the whole packet fits in the remaining slot budget, so no packet crosses a reconfiguration window.

---
 rtl/ocs_pkg.sv | 15 +
 rtl/ocs_rr_arbiter.sv | 27 ++
 rtl/ocs_tx_slot_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ocs_pkg.sv
// Shared OCS constants and the transmit scheduler state encoding.
package ocs_pkg;

    localparam int unsigned C_SLOT_LEN     = 32'h0000_5CD0;
    localparam int unsigned C_CONFIG_DELAY = 32'h0000_0100;
    localparam int unsigned C_GUARD        = 32'h0000_0040;
    localparam int unsigned C_BUDGET_W     = 16;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_ARB  = 2'd1,
        S_XFER = 2'd2
    } sched_state_t;

endpackage

// File: rtl/ocs_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after the pointer, wrapping.
module ocs_rr_arbiter #(
    parameter int unsigned P_NUM_REQ = 4,
    parameter int unsigned P_PTR_W   = $clog2(P_NUM_REQ)
) (
    input  logic [P_NUM_REQ-1:0] i_elig,
    input  logic [P_PTR_W-1:0]   i_rr_ptr,
    output logic [P_NUM_REQ-1:0] o_win_c,
    output logic                 o_valid_c
);

    logic [P_PTR_W-1:0] w_idx;

    always_comb begin
        o_win_c   = '0;
        o_valid_c = 1'b0;
        w_idx     = '0;
        for (int unsigned k = 0; k < P_NUM_REQ; k++) begin
            w_idx = P_PTR_W'((32'(i_rr_ptr) + k) % P_NUM_REQ);
            if (!o_valid_c && i_elig[w_idx]) begin
                o_win_c[w_idx] = 1'b1;
                o_valid_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ocs_tx_slot_sched.sv
// Per-slot TX scheduler: round-robin grants that only start when the whole packet
// fits in the remaining slot budget, so no packet straddles a reconfiguration.
module ocs_tx_slot_sched
    import ocs_pkg::*;
#(
    parameter int unsigned P_NUM_REQ  = 4,
    parameter int unsigned P_SLOT_LEN = C_SLOT_LEN,
    parameter int unsigned P_GUARD    = C_GUARD,
    parameter int unsigned P_LEN_W    = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_slot_start,
    input  logic                           i_slot_id,
    input  logic [P_NUM_REQ-1:0]           i_req,
    input  logic [P_NUM_REQ-1:0]           i_req_dest,
    input  logic [P_NUM_REQ*P_LEN_W-1:0]   i_req_len,
    input  logic                           i_tx_ready,
    output logic [P_NUM_REQ-1:0]           o_grant,
    output logic                           o_tx_active,
    output logic                           o_pkt_done,
    output logic                           o_abort,
    output logic                           o_slot_open
);

    localparam int unsigned PTR_W = $clog2(P_NUM_REQ);
    localparam int unsigned BUD_W = C_BUDGET_W;
    localparam int unsigned CMP_W = (P_LEN_W > BUD_W) ? P_LEN_W : BUD_W;
    localparam logic [BUD_W-1:0] BUDGET_LOAD = BUD_W'(P_SLOT_LEN - P_GUARD);

    sched_state_t           r_state;
    logic [BUD_W-1:0]       r_budget;
    logic                   r_slot_id;
    logic                   r_slot_open;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [P_LEN_W-1:0]     r_beats;
    logic [P_NUM_REQ-1:0]   r_grant;
    logic                   r_tx_active;
    logic                   r_pkt_done;
    logic                   r_abort;

    logic [P_LEN_W-1:0]     w_len_eff [P_NUM_REQ];
    logic [P_NUM_REQ-1:0]   w_elig;
    logic [P_NUM_REQ-1:0]   w_win;
    logic                   w_win_vld;
    logic [PTR_W-1:0]       w_win_idx;
    logic [P_LEN_W-1:0]     w_win_len;
    logic [PTR_W-1:0]       w_rr_nxt;

    // Zero-length heads still occupy one beat; fit check uses this cycle's budget.
    always_comb begin
        w_len_eff = '{default: '0};
        w_elig    = '0;
        for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
            w_len_eff[i] = (i_req_len[i*P_LEN_W +: P_LEN_W] == '0) ? P_LEN_W'(1)
                                                                   : i_req_len[i*P_LEN_W +: P_LEN_W];
            w_elig[i]    = i_req[i] & (i_req_dest[i] == r_slot_id)
                         & (CMP_W'(w_len_eff[i]) <= CMP_W'(r_budget));
        end
    end

    ocs_rr_arbiter #(
        .P_NUM_REQ (P_NUM_REQ),
        .P_PTR_W   (PTR_W)
    ) u_arb (
        .i_elig    (w_elig),
        .i_rr_ptr  (r_rr_ptr),
        .o_win_c   (w_win),
        .o_valid_c (w_win_vld)
    );

    always_comb begin
        w_win_idx = '0;
        for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
            if (w_win[i]) w_win_idx = PTR_W'(i);
        end
    end

    assign w_win_len = w_len_eff[w_win_idx];
    assign w_rr_nxt  = PTR_W'((32'(w_win_idx) + 32'd1) % P_NUM_REQ);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_WAIT;
            r_budget    <= '0;
            r_slot_id   <= 1'b0;
            r_slot_open <= 1'b0;
            r_rr_ptr    <= '0;
            r_beats     <= '0;
            r_grant     <= '0;
            r_tx_active <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            r_abort    <= 1'b0;

            if (i_slot_start) begin
                r_slot_id   <= i_slot_id;
                r_budget    <= BUDGET_LOAD;
                r_slot_open <= (BUDGET_LOAD != '0);
            end else if (r_budget != '0) begin
                r_budget    <= r_budget - BUD_W'(1);
                r_slot_open <= (r_budget != BUD_W'(1));
            end else begin
                r_slot_open <= 1'b0;
            end

            case (r_state)
                S_WAIT: begin
                    if (i_slot_start) r_state <= S_ARB;
                end
                S_ARB: begin
                    if (i_slot_start) begin
                        r_state <= S_ARB;
                    end else if (r_budget == '0) begin
                        r_state <= S_WAIT;
                    end else if (w_win_vld) begin
                        r_grant     <= w_win;
                        r_tx_active <= 1'b1;
                        r_beats     <= w_win_len;
                        r_rr_ptr    <= w_rr_nxt;
                        r_state     <= S_XFER;
                    end
                end
                S_XFER: begin
                    // A new slot wins over completion landing in the same cycle.
                    if (i_slot_start) begin
                        r_grant     <= '0;
                        r_tx_active <= 1'b0;
                        r_abort     <= 1'b1;
                        r_state     <= S_ARB;
                    end else if (i_tx_ready && (r_beats == P_LEN_W'(1))) begin
                        r_grant     <= '0;
                        r_tx_active <= 1'b0;
                        r_pkt_done  <= 1'b1;
                        r_state     <= S_ARB;
                    end else begin
                        if (i_tx_ready) r_beats <= r_beats - P_LEN_W'(1);
                        if (r_budget == '0) begin
                            r_grant     <= '0;
                            r_tx_active <= 1'b0;
                            r_abort     <= 1'b1;
                            r_state     <= S_WAIT;
                        end
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_tx_active = r_tx_active;
    assign o_pkt_done  = r_pkt_done;
    assign o_abort     = r_abort;
    assign o_slot_open = r_slot_open;

endmodule
